// File: rtl/bank_cmd_gate_if.sv
// Shared encodings for the bank command gate and its request/grant interface.
// The requester (main FSM side) uses the master modport, the gate uses slave.
`ifndef BANK_CMD_GATE_DEFS
`define BANK_CMD_GATE_DEFS
`define FSM_WIDTH1 4
`define BA_BITS 3
`endif

package bank_cmd_gate_pkg;
  localparam int FSM_W = `FSM_WIDTH1;
  localparam int BA_W  = `BA_BITS;

  localparam logic [FSM_W-1:0] FSM_IDLE    = 4'd0;
  localparam logic [FSM_W-1:0] FSM_ACTIVE  = 4'd1;
  localparam logic [FSM_W-1:0] FSM_READ    = 4'd2;
  localparam logic [FSM_W-1:0] FSM_WRITE   = 4'd3;
  localparam logic [FSM_W-1:0] FSM_PRE     = 4'd4;
  localparam logic [FSM_W-1:0] FSM_REFRESH = 4'd5;

  typedef enum logic [2:0] {
    CODE_IDLE                 = 3'd0,
    CODE_ACTIVE_TO_READ_WRITE = 3'd1,
    CODE_READ_TO_PRECHARGE    = 3'd2,
    CODE_WRITE_TO_PRECHARGE   = 3'd3,
    CODE_PRECHARGE_TO_ACTIVE  = 3'd4,
    CODE_PRECHARGE_TO_REFRESH = 3'd5,
    CODE_REFRESH_TO_ACTIVE    = 3'd6,
    CODE_POWER_DOWN           = 3'd7
  } recode_state_t;
endpackage

interface bank_cmd_gate_if;
  import bank_cmd_gate_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [FSM_W-1:0] req_cmd;
  logic [BA_W-1:0]  req_bank;
  logic             grant_valid;
  logic [FSM_W-1:0] grant_cmd;
  logic [BA_W-1:0]  grant_bank;

  modport master (
    output req_valid, req_cmd, req_bank,
    input  req_ready, grant_valid, grant_cmd, grant_bank
  );

  modport slave (
    input  req_valid, req_cmd, req_bank,
    output req_ready, grant_valid, grant_cmd, grant_bank
  );
endinterface

// File: rtl/bank_cmd_gate.sv
// Per-bank command-issue gate: checks a request against the bank's recode,
// holds it until the timing counters and refresh allow, then pulses a grant.
//
// state     | meaning
// IDLE      | ready for a request addressed to this bank
// CHECK     | legality of captured command against recode
// WAIT      | stalling on tP / tRAS / refresh, counting stall cycles
// GRANT     | one-cycle issue pulse toward the main FSM
// ERR_ILL   | one-cycle illegal-command pulse
// ERR_TO    | one-cycle timeout pulse
module bank_cmd_gate
  import bank_cmd_gate_pkg::*;
#(
  parameter int BANK_ID  = 0,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  bank_cmd_gate_if.slave      bus,
  input  logic [4:0]          tP_ba_counter_i,
  input  logic [5:0]          tRAS_counter_i,
  input  recode_state_t       recode_i,
  input  logic                refresh_flag_i,
  output logic                busy_o,
  output logic                err_illegal_o,
  output logic                err_timeout_o,
  output logic [CNT_W-1:0]    wait_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT, S_GRANT, S_ERR_ILL, S_ERR_TO
  } state_e;

  state_e           state_q, state_d;
  logic [FSM_W-1:0] cmd_q, cmd_d;
  logic [BA_W-1:0]  bank_q, bank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic             grant_valid_q, grant_valid_d;
  logic [FSM_W-1:0] grant_cmd_q, grant_cmd_d;
  logic [BA_W-1:0]  grant_bank_q, grant_bank_d;
  logic             busy_q, busy_d;
  logic             err_ill_q, err_ill_d;
  logic             err_to_q, err_to_d;
  logic [CNT_W-1:0] wait_cycles_q, wait_cycles_d;

  logic req_ready;
  logic legal;
  logic issue_ok;

  assign req_ready = (state_q == S_IDLE) && (bus.req_bank == BA_W'(BANK_ID)) && !refresh_flag_i;

  always_comb begin
    legal = 1'b0;
    case (cmd_q)
      FSM_ACTIVE: legal = recode_i inside {CODE_IDLE, CODE_PRECHARGE_TO_ACTIVE,
                                           CODE_PRECHARGE_TO_REFRESH};
      FSM_READ, FSM_WRITE, FSM_PRE:
        legal = recode_i inside {CODE_ACTIVE_TO_READ_WRITE, CODE_READ_TO_PRECHARGE,
                                 CODE_WRITE_TO_PRECHARGE};
      default: legal = 1'b0;
    endcase
  end

  // READ-after-WRITE is not special-cased: it waits the full tP_ba_counter.
  assign issue_ok = (tP_ba_counter_i == 5'd0) && !refresh_flag_i &&
                    ((cmd_q != FSM_PRE) || (tRAS_counter_i == 6'd0));

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          cmd_d   = bus.req_cmd;
          bank_d  = bus.req_bank;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (legal) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ERR_ILL;
        end
      end
      S_WAIT: begin
        if (issue_ok) begin
          state_d = S_GRANT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_WAIT)) state_d = S_ERR_TO;
        end
      end
      S_GRANT, S_ERR_ILL, S_ERR_TO: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, decoded from the state being entered.
    grant_valid_d = (state_d == S_GRANT);
    err_ill_d     = (state_d == S_ERR_ILL);
    err_to_d      = (state_d == S_ERR_TO);
    busy_d        = (state_d != S_IDLE);
    grant_cmd_d   = (state_d == S_GRANT) ? cmd_d  : grant_cmd_q;
    grant_bank_d  = (state_d == S_GRANT) ? bank_d : grant_bank_q;
    wait_cycles_d = wait_cycles_q;
    if (state_d == S_GRANT)  wait_cycles_d = cnt_d;
    if (state_d == S_ERR_TO) wait_cycles_d = CNT_W'(MAX_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      bank_q        <= '0;
      cnt_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_cmd_q   <= '0;
      grant_bank_q  <= '0;
      busy_q        <= 1'b0;
      err_ill_q     <= 1'b0;
      err_to_q      <= 1'b0;
      wait_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      bank_q        <= bank_d;
      cnt_q         <= cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_cmd_q   <= grant_cmd_d;
      grant_bank_q  <= grant_bank_d;
      busy_q        <= busy_d;
      err_ill_q     <= err_ill_d;
      err_to_q      <= err_to_d;
      wait_cycles_q <= wait_cycles_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_cmd   = grant_cmd_q;
  assign bus.grant_bank  = grant_bank_q;
  assign busy_o          = busy_q;
  assign err_illegal_o   = err_ill_q;
  assign err_timeout_o   = err_to_q;
  assign wait_cycles_o   = wait_cycles_q;

endmodule

// File: tb/tb_bank_cmd_gate.sv
// Bench for bank_cmd_gate: directed and random requests checked against a
// transaction-level model that predicts outcome, latency and stall count.
module tb_bank_cmd_gate;
  import bank_cmd_gate_pkg::*;

  localparam int BANK = 2;
  localparam int MAXW = 16;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    tp;
  logic [5:0]    tras;
  recode_state_t rec;
  logic          refr;
  logic          busy, err_ill, err_to;
  logic [CW-1:0] wc;

  always #5 clk = ~clk;

  bank_cmd_gate_if bus();

  bank_cmd_gate #(.BANK_ID(BANK), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .tP_ba_counter_i (tp),
    .tRAS_counter_i  (tras),
    .recode_i        (rec),
    .refresh_flag_i  (refr),
    .busy_o          (busy),
    .err_illegal_o   (err_ill),
    .err_timeout_o   (err_to),
    .wait_cycles_o   (wc)
  );

  int n_chk = 0;
  int n_err = 0;

  // Per-cycle input schedule, indexed by cycle number after the handshake edge.
  logic [4:0] tp_s   [64];
  logic [5:0] tras_s [64];
  bit         ref_s  [64];

  logic [FSM_W-1:0] last_gcmd  = '0;
  logic [BA_W-1:0]  last_gbank = '0;
  logic [CW-1:0]    last_wc    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [FSM_W-1:0] c, input recode_state_t r);
    bit act_row, rw_row;
    act_row = (r == CODE_IDLE) || (r == CODE_PRECHARGE_TO_ACTIVE) || (r == CODE_PRECHARGE_TO_REFRESH);
    rw_row  = (r == CODE_ACTIVE_TO_READ_WRITE) || (r == CODE_READ_TO_PRECHARGE) ||
              (r == CODE_WRITE_TO_PRECHARGE);
    if (c == FSM_ACTIVE) return act_row;
    if (c == FSM_READ || c == FSM_WRITE || c == FSM_PRE) return rw_row;
    return 1'b0;
  endfunction

  task automatic fill(input int tpv, input int tpn, input int trv, input int trn, input int rfn);
    for (int i = 0; i < 64; i++) begin
      tp_s[i]   = (i >= 2 && i < 2 + tpn) ? 5'(tpv) : 5'd0;
      tras_s[i] = (i >= 2 && i < 2 + trn) ? 6'(trv) : 6'd0;
      ref_s[i]  = (i >= 2 && i < 2 + rfn);
    end
  endtask

  task automatic drive(input int n);
    tp   = tp_s[n];
    tras = tras_s[n];
    refr = ref_s[n];
  endtask

  // Starts #1 after a rising edge with the DUT idle; ends likewise.
  task automatic run_txn(input logic [FSM_W-1:0] c, input recode_state_t r);
    int kind;   // 0 grant, 1 illegal, 2 timeout
    int endc;
    int s;
    logic [CW-1:0] new_wc;
    s = 0;
    if (!ref_legal(c, r)) begin
      kind = 1; endc = 2;
    end else begin
      while (s < MAXW) begin
        if (tp_s[2+s] == 0 && !ref_s[2+s] && (c != FSM_PRE || tras_s[2+s] == 0)) break;
        s++;
      end
      if (s == MAXW) begin kind = 2; endc = 2 + MAXW; end
      else begin kind = 0; endc = 3 + s; end
    end
    new_wc = (kind == 0) ? CW'(s) : (kind == 2) ? CW'(MAXW) : last_wc;

    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_bank  = BA_W'(BANK);
    refr = 1'b0;
    rec  = r;
    tp   = 5'($urandom);
    tras = 6'($urandom);
    @(negedge clk);
    chk("ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drive(1);
    for (int n = 1; n <= endc; n++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("ready_busy", bus.req_ready, 0);
      chk("grant_valid", bus.grant_valid, (kind == 0 && n == endc));
      chk("err_illegal", err_ill, (kind == 1 && n == endc));
      chk("err_timeout", err_to, (kind == 2 && n == endc));
      if (kind == 0 && n == endc) begin
        chk("grant_cmd", bus.grant_cmd, c);
        chk("grant_bank", bus.grant_bank, BANK);
      end else begin
        chk("grant_cmd_hold", bus.grant_cmd, last_gcmd);
      end
      if (n == endc) chk("wait_cycles", wc, new_wc);
      @(posedge clk); #1;
      drive(n + 1);
    end
    if (kind == 0) begin last_gcmd = c; last_gbank = BA_W'(BANK); end
    last_wc = new_wc;
    refr = 1'b0;
    tp   = '0;
    tras = '0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("ready_after", bus.req_ready, 1);
    chk("grant_valid_after", bus.grant_valid, 0);
    chk("wait_cycles_after", wc, last_wc);
    chk("grant_cmd_after", bus.grant_cmd, last_gcmd);
    chk("grant_bank_after", bus.grant_bank, last_gbank);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gv"}, bus.grant_valid, 0);
    chk({tag, "_gcmd"}, bus.grant_cmd, 0);
    chk({tag, "_gbank"}, bus.grant_bank, 0);
    chk({tag, "_eill"}, err_ill, 0);
    chk({tag, "_eto"}, err_to, 0);
    chk({tag, "_wc"}, wc, 0);
  endtask

  initial begin
    recode_state_t act_l [3];
    recode_state_t rw_l  [3];
    logic [FSM_W-1:0] c;
    recode_state_t r;
    int rate;
    act_l = '{CODE_IDLE, CODE_PRECHARGE_TO_ACTIVE, CODE_PRECHARGE_TO_REFRESH};
    rw_l  = '{CODE_ACTIVE_TO_READ_WRITE, CODE_READ_TO_PRECHARGE, CODE_WRITE_TO_PRECHARGE};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_bank  = BA_W'(BANK);
    tp = '0; tras = '0; refr = 1'b0; rec = CODE_IDLE;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases.
    fill(0, 0, 0, 0, 0);   run_txn(FSM_ACTIVE, CODE_IDLE);
    fill(3, 4, 0, 0, 0);   run_txn(FSM_READ, CODE_ACTIVE_TO_READ_WRITE);
    fill(0, 0, 0, 0, 0);   run_txn(FSM_WRITE, CODE_IDLE);
    fill(0, 0, 10, 5, 0);  run_txn(FSM_PRE, CODE_READ_TO_PRECHARGE);
    fill(7, 63, 0, 0, 0);  run_txn(FSM_ACTIVE, CODE_PRECHARGE_TO_ACTIVE);
    fill(0, 0, 0, 0, 3);   run_txn(FSM_READ, CODE_WRITE_TO_PRECHARGE);
    fill(0, 0, 20, 8, 0);  run_txn(FSM_WRITE, CODE_ACTIVE_TO_READ_WRITE);
    fill(0, 0, 0, 0, 0);   ref_s[1] = 1'b1; run_txn(FSM_ACTIVE, CODE_PRECHARGE_TO_REFRESH);

    // Acceptance gating.
    bus.req_valid = 1'b1; bus.req_cmd = FSM_ACTIVE; bus.req_bank = 3'd5; rec = CODE_IDLE;
    @(negedge clk); chk("ready_wrong_bank", bus.req_ready, 0);
    bus.req_bank = BA_W'(BANK); refr = 1'b1;
    @(negedge clk); chk("ready_refresh", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; refr = 1'b0;
    @(negedge clk); chk("no_accept_busy", busy, 0);
    chk("ready_back", bus.req_ready, 1);
    @(posedge clk); #1;

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      rate = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) begin
        tp_s[i]   = ($urandom_range(0, 3) < rate) ? 5'($urandom_range(1, 31)) : 5'd0;
        tras_s[i] = ($urandom_range(0, 3) < rate) ? 6'($urandom_range(1, 63)) : 6'd0;
        ref_s[i]  = ($urandom_range(0, 7) == 0);
      end
      c = FSM_W'($urandom_range(0, 5));
      r = recode_state_t'(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0)
        r = (c == FSM_ACTIVE) ? act_l[$urandom_range(0, 2)] : rw_l[$urandom_range(0, 2)];
      run_txn(c, r);
    end

    // Reset in the middle of WAIT drops the request.
    fill(7, 63, 0, 0, 0);
    bus.req_valid = 1'b1; bus.req_cmd = FSM_ACTIVE; bus.req_bank = BA_W'(BANK);
    rec = CODE_IDLE; refr = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    tp = 5'd7;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    #2 rst = 1'b0;
    tp = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_gv", bus.grant_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_err", {err_ill, err_to}, 0);
    end
    @(posedge clk); #1;
    last_gcmd = '0; last_gbank = '0; last_wc = '0;
    fill(0, 0, 0, 0, 0);
    run_txn(FSM_ACTIVE, CODE_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
